instr_fetch_unit: RTL

Instruction fetch stage sitting between the instruction memory and decode/register-file read inside `cpu`. Owns the fetch program counter and issues word-addressed reads to instruction memory with at most one request outstanding. Buffers returned instructions with their PCs in a 4-entry FIFO and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects, which flush the FIFO and discard any in-flight response.

---
 rtl/instr_fetch_unit_if.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_fetch_unit_if
// Purpose   : Instruction-memory, redirect and decode handshake signals of
//             the fetch stage. The master modport is the fetch unit itself.
// Revision  : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int WIDTH      = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_req;
    logic [WIDTH-1:0]      imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_rvalid;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [WIDTH-1:0]      id_pc;
    logic                  id_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Owns the fetch PC, keeps at most one instruction-memory read in
//            flight and queues (pc, instr) pairs for decode; redirects flush.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int WIDTH      = 12,
    parameter int DATA_WIDTH = 16,
    parameter int RESET_PC   = 0,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int               c_PTR_W    = $clog2(DEPTH);
    localparam int               c_CNT_W    = c_PTR_W + 1;
    localparam logic [WIDTH-1:0] c_RESET_PC = WIDTH'(RESET_PC);
    localparam logic [c_CNT_W:0] c_DEPTH_S  = (c_CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]      r_pc;
    logic [WIDTH-1:0]      r_req_pc;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_instr [DEPTH];
    logic [WIDTH-1:0]      r_fifo_pc    [DEPTH];

    logic                  w_head_valid;
    logic                  w_busy;
    logic                  w_deq;
    logic                  w_push;
    logic                  w_req;
    logic [c_CNT_W:0]      w_slots;

    // Slots counts buffered entries plus the one already promised to the
    // in-flight kept response, so a new request can never overflow the FIFO.
    always_comb begin
        w_head_valid = (r_count != '0);
        w_busy       = (r_state == ST_BUSY);
        w_deq        = w_head_valid && bus.id_ready;
        w_slots      = {1'b0, r_count}
                     + (c_CNT_W + 1)'(w_busy)
                     - (c_CNT_W + 1)'(w_deq);
        w_req        = !reset
                    && !bus.redirect_valid
                    && (w_slots < c_DEPTH_S)
                    && ((r_state == ST_IDLE) || bus.imem_rvalid);
        w_push       = w_busy && bus.imem_rvalid && !bus.redirect_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            case (r_state)
                ST_BUSY: w_state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
                ST_DROP: w_state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_req) begin
            w_state_nxt = ST_BUSY;
        end else if (bus.imem_rvalid && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= c_RESET_PC;
            r_req_pc <= c_RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc     <= bus.redirect_pc;
        end else if (w_req) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + WIDTH'(1);
        end
    end

    // A dequeue in a redirect cycle is simply absorbed by the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_deq);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = w_head_valid;
    assign bus.id_instr  = w_head_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign bus.id_pc     = w_head_valid ? r_fifo_pc[r_rd_ptr]    : '0;

endmodule
`default_nettype wire
